// File: rtl/sequenceur_chute.sv
// Brick-game sequencer: spawns a brick, drops it one row per tick, signals landing,
// row clearing (aligne) and game over (perdu) to the three pile counters.
module sequenceur_chute #(
    parameter int NB_LIGNES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       tick,
    input  logic [1:0] col,
    input  logic [2:0] hauteurGauche,
    input  logic [2:0] hauteurCentre,
    input  logic [2:0] hauteurDroite,
    output logic       plusGauche,
    output logic       plusCentre,
    output logic       plusDroite,
    output logic       aligne,
    output logic       perdu,
    output logic [2:0] row,
    output logic       actif
);

    typedef enum logic [3:0] {
        ATTENTE, APPARITION, CHUTE, POSE, MAJ, VERIF, RETRAIT, MAJ2, FIN
    } etat_t;

    localparam logic [3:0] LIM_POSE = 4'(NB_LIGNES - 1);
    localparam logic [3:0] LIM_PLEIN = 4'(NB_LIGNES);

    etat_t      r_state, w_state;
    logic [2:0] r_row, w_row;
    logic       r_actif, w_actif;
    logic       r_perdu, w_perdu;
    logic       r_aligne, w_aligne;
    logic [2:0] r_plus, w_plus;

    logic [2:0] w_h;
    logic [2:0] w_colsel;
    logic [3:0] w_sum;
    logic       w_plein;
    logic       w_ligne;

    // Column 3 is folded onto the centre column.
    always_comb begin
        w_h      = hauteurCentre;
        w_colsel = 3'b010;
        if (col == 2'd0) begin
            w_h      = hauteurGauche;
            w_colsel = 3'b001;
        end else if (col == 2'd2) begin
            w_h      = hauteurDroite;
            w_colsel = 3'b100;
        end
    end

    assign w_sum   = {1'b0, r_row} + {1'b0, w_h};
    assign w_plein = ({1'b0, hauteurGauche} >= LIM_PLEIN) ||
                     ({1'b0, hauteurCentre} >= LIM_PLEIN) ||
                     ({1'b0, hauteurDroite} >= LIM_PLEIN);
    assign w_ligne = (hauteurGauche != 3'd0) && (hauteurCentre != 3'd0) &&
                     (hauteurDroite != 3'd0);

    // Outputs are computed for the next state and registered with it.
    always_comb begin
        w_state  = r_state;
        w_row    = r_row;
        w_actif  = r_actif;
        w_perdu  = r_perdu;
        w_plus   = 3'b000;
        w_aligne = 1'b0;
        case (r_state)
            ATTENTE: if (enable) w_state = APPARITION;
            APPARITION: begin
                w_row   = 3'd0;
                w_actif = 1'b1;
                w_state = CHUTE;
            end
            CHUTE: begin
                if (tick && enable) begin
                    if (w_sum >= LIM_POSE) begin
                        w_state = POSE;
                        w_actif = 1'b0;
                        w_plus  = w_colsel;
                    end else begin
                        w_row = r_row + 3'd1;
                    end
                end
            end
            POSE: w_state = MAJ;
            MAJ:  w_state = VERIF;
            VERIF: begin
                if (w_plein) begin
                    w_state = FIN;
                    w_perdu = 1'b1;
                    w_actif = 1'b0;
                end else if (w_ligne) begin
                    w_state  = RETRAIT;
                    w_aligne = 1'b1;
                end else begin
                    w_state = APPARITION;
                end
            end
            RETRAIT: w_state = MAJ2;
            MAJ2:    w_state = APPARITION;
            FIN: begin
                w_perdu = 1'b1;
                w_actif = 1'b0;
            end
            default: w_state = ATTENTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ATTENTE;
            r_row    <= 3'd0;
            r_actif  <= 1'b0;
            r_perdu  <= 1'b0;
            r_aligne <= 1'b0;
            r_plus   <= 3'b000;
        end else begin
            r_state  <= w_state;
            r_row    <= w_row;
            r_actif  <= w_actif;
            r_perdu  <= w_perdu;
            r_aligne <= w_aligne;
            r_plus   <= w_plus;
        end
    end

    assign plusGauche = r_plus[0];
    assign plusCentre = r_plus[1];
    assign plusDroite = r_plus[2];
    assign aligne     = r_aligne;
    assign perdu      = r_perdu;
    assign row        = r_row;
    assign actif      = r_actif;

endmodule
